// File: rtl/generator_uzoraka.sv
// ============================================================================
//  Module      : generator_uzoraka
//  Description : Exhaustive stimulus-and-capture engine for an N-input gate;
//                sweeps all vectors, builds the truth table, flags mismatch.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module generator_uzoraka #(
  parameter int N    = 2,
  parameter int HOLD = 2,
  parameter int GRAY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2**N-1:0]   ocekivano,
  input  logic              dut_izlaz,
  output logic [N-1:0]      uzorak,
  output logic [2**N-1:0]   tablica,
  output logic              busy,
  output logic              done,
  output logic              greska
);

  localparam int c_tab_w = 2**N;
  localparam int c_cnt_w = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(HOLD - 1);
  localparam logic [N-1:0]       c_i_last   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state, w_state_n;
  logic [N-1:0]         r_i, w_i_n;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_n;
  logic [N-1:0]         r_uzorak, w_uzorak_n;
  logic [c_tab_w-1:0]   r_tablica, w_tablica_n;
  logic                 r_busy, w_busy_n;
  logic                 r_done, w_done_n;
  logic                 r_greska, w_greska_n;

  // Sweep index to driven vector: identity or reflected Gray code.
  function automatic logic [N-1:0] f_vector(input logic [N-1:0] idx);
    if (GRAY != 0) return idx ^ (idx >> 1);
    else           return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_cnt     <= '0;
      r_uzorak  <= '0;
      r_tablica <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_greska  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_i       <= w_i_n;
      r_cnt     <= w_cnt_n;
      r_uzorak  <= w_uzorak_n;
      r_tablica <= w_tablica_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_greska  <= w_greska_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_i_n       = r_i;
    w_cnt_n     = r_cnt;
    w_uzorak_n  = r_uzorak;
    w_tablica_n = r_tablica;
    w_busy_n    = r_busy;
    w_done_n    = r_done;
    w_greska_n  = r_greska;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_n   = S_RUN;
          w_i_n       = '0;
          w_cnt_n     = '0;
          w_uzorak_n  = f_vector('0);
          w_tablica_n = '0;
          w_busy_n    = 1'b1;
          w_done_n    = 1'b0;
          w_greska_n  = 1'b0;
        end
      end

      S_RUN: begin
        if (r_cnt == c_cnt_last) begin
          // Indexed by vector value so Gray sweeps yield the binary-order table.
          w_tablica_n[r_uzorak] = dut_izlaz;
          if (r_i == c_i_last) begin
            w_state_n  = S_DONE;
            w_busy_n   = 1'b0;
            w_done_n   = 1'b1;
            w_uzorak_n = '0;
            w_greska_n = (w_tablica_n != ocekivano);
          end else begin
            w_i_n      = r_i + N'(1);
            w_uzorak_n = f_vector(r_i + N'(1));
            w_cnt_n    = '0;
          end
        end else begin
          w_cnt_n = r_cnt + c_cnt_w'(1);
        end
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign uzorak  = r_uzorak;
  assign tablica = r_tablica;
  assign busy    = r_busy;
  assign done    = r_done;
  assign greska  = r_greska;

endmodule

`default_nettype wire

// File: tb/tb_generator_uzoraka.sv
// ============================================================================
//  Module      : tb_generator_uzoraka
//  Description : Bench for generator_uzoraka with an AND2 (binary, HOLD=2)
//                and an XOR3 (Gray, HOLD=1) gate under test.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_generator_uzoraka;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [3:0] ocek_a;
  logic [7:0] ocek_b;
  logic       izlaz_a, izlaz_b;
  logic [1:0] uzorak_a;
  logic [2:0] uzorak_b;
  logic [3:0] tablica_a;
  logic [7:0] tablica_b;
  logic       busy_a, busy_b, done_a, done_b, greska_a, greska_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] q_a[$];
  logic [2:0] q_b[$];

  always #5 clk = ~clk;

  assign izlaz_a = &uzorak_a;
  assign izlaz_b = ^uzorak_b;

  generator_uzoraka #(.N(2), .HOLD(2), .GRAY(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .ocekivano(ocek_a),
    .dut_izlaz(izlaz_a), .uzorak(uzorak_a), .tablica(tablica_a),
    .busy(busy_a), .done(done_a), .greska(greska_a)
  );

  generator_uzoraka #(.N(3), .HOLD(1), .GRAY(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .ocekivano(ocek_b),
    .dut_izlaz(izlaz_b), .uzorak(uzorak_b), .tablica(tablica_b),
    .busy(busy_b), .done(done_b), .greska(greska_b)
  );

  // Instance A outputs packed as {uzorak, tablica, busy, done, greska}.
  task automatic check_a_idle_zero(input string name);
    n_checks++;
    if ({uzorak_a, tablica_a, busy_a, done_a, greska_a} !== 9'd0) begin
      n_fail++;
      $display("FAIL %s: got uzorak=%0d tablica=%b busy=%b done=%b greska=%b, want all 0",
               name, uzorak_a, tablica_a, busy_a, done_a, greska_a);
    end
  endtask

  // Sweep on instance A; optional extra start pulse at cycle extra_start.
  task automatic run_sweep_a(input logic [3:0] ocek, input logic [3:0] exp_tab,
                             input logic exp_gr, input int extra_start);
    logic [1:0] exp_v;
    int k;
    ocek_a = ocek;
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 2; h++) q_a.push_back(2'(v));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    while (q_a.size() > 0) begin
      exp_v = q_a.pop_front();
      n_checks++;
      if (uzorak_a !== exp_v || busy_a !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_a_c%0d: got uzorak=%0d busy=%b, want uzorak=%0d busy=1",
                 k, uzorak_a, busy_a, exp_v);
      end
      if (k == 0) begin
        n_checks++;
        if (done_a !== 1'b0 || tablica_a !== 4'b0000 || greska_a !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep_a_start: got done=%b tablica=%b greska=%b, want 0 0000 0",
                   done_a, tablica_a, greska_a);
        end
      end
      if (k == extra_start) start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      k++;
    end
    n_checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b1 || uzorak_a !== 2'd0) begin
      n_fail++;
      $display("FAIL sweep_a_end: got busy=%b done=%b uzorak=%0d, want 0 1 0",
               busy_a, done_a, uzorak_a);
    end
    n_checks++;
    if (tablica_a !== exp_tab || greska_a !== exp_gr) begin
      n_fail++;
      $display("FAIL sweep_a_result: got tablica=%b greska=%b, want %b %b",
               tablica_a, greska_a, exp_tab, exp_gr);
    end
    @(negedge clk);
    n_checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || tablica_a !== exp_tab || greska_a !== exp_gr) begin
      n_fail++;
      $display("FAIL sweep_a_hold: got done=%b busy=%b tablica=%b greska=%b, want 1 0 %b %b",
               done_a, busy_a, tablica_a, greska_a, exp_tab, exp_gr);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; ocek_a = '0; ocek_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_a_idle_zero("reset_a");
    n_checks++;
    if ({uzorak_b, tablica_b, busy_b, done_b, greska_b} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_b: got uzorak=%0d tablica=%b busy=%b done=%b greska=%b, want all 0",
               uzorak_b, tablica_b, busy_b, done_b, greska_b);
    end
  endtask

  task automatic test_and_match;
    run_sweep_a(4'b1000, 4'b1000, 1'b0, -1);
  endtask

  task automatic test_or_mismatch;
    run_sweep_a(4'b1110, 4'b1000, 1'b1, -1);
  endtask

  task automatic test_gray_xor;
    logic [2:0] seq [8];
    logic [2:0] exp_v;
    int k;
    seq = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    ocek_b = 8'b10010110;
    for (int j = 0; j < 8; j++) q_b.push_back(seq[j]);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    k = 0;
    while (q_b.size() > 0) begin
      exp_v = q_b.pop_front();
      n_checks++;
      if (uzorak_b !== exp_v || busy_b !== 1'b1) begin
        n_fail++;
        $display("FAIL gray_c%0d: got uzorak=%0d busy=%b, want uzorak=%0d busy=1",
                 k, uzorak_b, busy_b, exp_v);
      end
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || tablica_b !== 8'b10010110 || greska_b !== 1'b0) begin
      n_fail++;
      $display("FAIL gray_result: got done=%b busy=%b tablica=%b greska=%b, want 1 0 10010110 0",
               done_b, busy_b, tablica_b, greska_b);
    end
  endtask

  task automatic test_reset_mid;
    int t;
    ocek_a = 4'b1000;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    t = 0;
    while (uzorak_a !== 2'd2 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (uzorak_a !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got uzorak=%0d, want 2 within 20 cycles", uzorak_a);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_a_idle_zero("reset_mid_a");
    @(negedge clk);
    check_a_idle_zero("reset_mid_idle");
    run_sweep_a(4'b1000, 4'b1000, 1'b0, -1);
  endtask

  task automatic test_start_in_run;
    run_sweep_a(4'b1000, 4'b1000, 1'b0, 2);
  endtask

  task automatic test_back_to_back;
    run_sweep_a(4'b1110, 4'b1000, 1'b1, -1);
    run_sweep_a(4'b1000, 4'b1000, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_and_match();
    test_or_mismatch();
    test_gray_xor();
    test_reset_mid();
    test_start_in_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
